// File: rtl/ivl_ovl_fire_arbiter.sv
// Counts qualified OVL checker fire cycles per checker and
// round-robin arbitrates the counts onto one valid/ready report port.
module ivl_ovl_fire_arbiter #(
    parameter int N_CHK = 4,
    parameter int CNT_W = 8,
    parameter int ID_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_CHK-1:0] chk_mask,
    input  logic [N_CHK-1:0] fire,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [ID_W-1:0]  rpt_id,
    output logic [CNT_W-1:0] rpt_count,
    output logic [N_CHK-1:0] pending,
    output logic             err_seen
);

    typedef enum logic {
        IDLE,
        REPORT
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q [N_CHK];
    logic [CNT_W-1:0] cnt_d [N_CHK];
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  ptr_d;
    logic             rpt_valid_q;
    logic [ID_W-1:0]  rpt_id_q;
    logic [CNT_W-1:0] rpt_count_q;
    logic             err_q;

    logic [N_CHK-1:0] qual;
    logic             hi_vld;
    logic             lo_vld;
    logic [ID_W-1:0]  hi_id;
    logic [ID_W-1:0]  lo_id;
    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_id;
    logic             grant;
    logic [CNT_W-1:0] gnt_cnt;
    logic [CNT_W-1:0] base;

    // X or Z on a fire bit is treated as no fire
    always_comb begin
        qual = '0;
        for (int i = 0; i < N_CHK; i++) begin
            qual[i] = enable & chk_mask[i] & (fire[i] === 1'b1);
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < N_CHK; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    // Lowest pending index at or above the pointer, else lowest overall
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        for (int i = N_CHK - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_vld = 1'b1;
                lo_id  = ID_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_vld = 1'b1;
                    hi_id  = ID_W'(i);
                end
            end
        end
        gnt_vld = hi_vld | lo_vld;
        gnt_id  = hi_vld ? hi_id : lo_id;
        grant   = (state_q == IDLE) && gnt_vld;
    end

    // The granted counter restarts from zero; a fire in the grant cycle counts as 1
    always_comb begin
        gnt_cnt = '0;
        base    = '0;
        for (int i = 0; i < N_CHK; i++) begin
            base = cnt_q[i];
            if (grant && (gnt_id == ID_W'(i))) begin
                gnt_cnt = cnt_q[i];
                base    = '0;
            end
            if (qual[i] && (base != {CNT_W{1'b1}})) begin
                cnt_d[i] = base + CNT_W'(1);
            end else begin
                cnt_d[i] = base;
            end
        end
    end

    always_comb begin
        if (int'(rpt_id_q) >= N_CHK - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = rpt_id_q + ID_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            rpt_valid_q <= 1'b0;
            rpt_id_q    <= '0;
            rpt_count_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < N_CHK; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CHK; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (|qual) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        rpt_valid_q <= 1'b1;
                        rpt_id_q    <= gnt_id;
                        rpt_count_q <= gnt_cnt;
                        state_q     <= REPORT;
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid_q <= 1'b0;
                        rr_ptr_q    <= ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rpt_valid = rpt_valid_q;
    assign rpt_id    = rpt_id_q;
    assign rpt_count = rpt_count_q;
    assign err_seen  = err_q;

endmodule
